// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single core memory port between the instruction-fetch requester
// (port I) and the load/store requester (port D). One access is outstanding
// at a time. Ties are broken round-robin against the last granted port. The
// winning address, write data and byte enables are registered onto the memory
// port, and the strobe is held until the memory reports completion. Read data
// is passed straight back to the winner together with a one-cycle valid pulse.
//
// Ports
//   clk          core clock, rising edge
//   reset_i      synchronous, active-high reset
//   I_addr_i     instruction fetch address
//   I_read_i     instruction read request, held until I_valid_o
//   I_data_o     instruction read data, zero unless I_valid_o
//   I_valid_o    one-cycle completion pulse for port I
//   D_addr_i     data address
//   D_read_i     data read request, held until D_valid_o
//   D_write_i    data write request, held until D_valid_o
//   D_wdata_i    data write data
//   D_be_i       data write byte enables
//   D_rdata_o    data read data, zero unless D_valid_o
//   D_valid_o    one-cycle completion pulse for port D (read or write)
//   MEM_addr_o   registered address of the granted access
//   MEM_read_o   memory read strobe, held for the whole access
//   MEM_write_o  memory write strobe, held for the whole access
//   MEM_wdata_o  registered write data
//   MEM_be_o     registered byte enables (all ones for reads)
//   MEM_data_i   memory read data
//   MEM_valid_i  memory completion
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               reset_i,

    input  logic [BITSIZE-1:0] I_addr_i,
    input  logic               I_read_i,
    output logic [31:0]        I_data_o,
    output logic               I_valid_o,

    input  logic [BITSIZE-1:0] D_addr_i,
    input  logic               D_read_i,
    input  logic               D_write_i,
    input  logic [31:0]        D_wdata_i,
    input  logic [3:0]         D_be_i,
    output logic [31:0]        D_rdata_o,
    output logic               D_valid_o,

    output logic [BITSIZE-1:0] MEM_addr_o,
    output logic               MEM_read_o,
    output logic               MEM_write_o,
    output logic [31:0]        MEM_wdata_o,
    output logic [3:0]         MEM_be_o,
    input  logic [31:0]        MEM_data_i,
    input  logic               MEM_valid_i
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         state_q,      state_d;
    logic               last_grant_q, last_grant_d;
    logic [BITSIZE-1:0] mem_addr_q,   mem_addr_d;
    logic               mem_read_q,   mem_read_d;
    logic               mem_write_q,  mem_write_d;
    logic [31:0]        mem_wdata_q,  mem_wdata_d;
    logic [3:0]         mem_be_q,     mem_be_d;

    // ------------------------------------------------------------------------
    // Request vectors and completion
    // ------------------------------------------------------------------------
    logic req_i;
    logic req_d;
    logic done_i;
    logic done_d;
    logic grant_i;
    logic grant_d;

    assign req_i = I_read_i;
    assign req_d = D_read_i | D_write_i;

    // Completion is gated by reset so an access abandoned by reset never
    // reports a valid, even when the memory answers in that same cycle.
    assign done_i = (state_q == ST_BUSY_I) & MEM_valid_i & ~reset_i;
    assign done_d = (state_q == ST_BUSY_D) & MEM_valid_i & ~reset_i;

    // ------------------------------------------------------------------------
    // Grant decision
    //
    // In IDLE both ports compete and the one that did not win last time gets
    // the port. On completion the finishing port's request is ignored for this
    // cycle (it is still held high by protocol), so the other port is granted
    // directly without an IDLE bubble if it is waiting.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned; without that, synthesis infers a latch.
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i && (!req_d || last_grant_q == GNT_D)) begin
                    grant_i = 1'b1;
                end else if (req_d) begin
                    grant_d = 1'b1;
                end
            end
            ST_BUSY_I: begin
                if (done_i && req_d) begin
                    grant_d = 1'b1;
                end
            end
            ST_BUSY_D: begin
                if (done_d && req_i) begin
                    grant_i = 1'b1;
                end
            end
            default: begin
                grant_i = 1'b0;
                grant_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state and memory-port register logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;

        if (grant_i) begin
            state_d      = ST_BUSY_I;
            last_grant_d = GNT_I;
            mem_addr_d   = I_addr_i;
            mem_read_d   = 1'b1;
            mem_write_d  = 1'b0;
            mem_be_d     = 4'hF;
        end else if (grant_d) begin
            state_d      = ST_BUSY_D;
            last_grant_d = GNT_D;
            mem_addr_d   = D_addr_i;
            mem_read_d   = D_read_i;
            mem_write_d  = D_write_i;
            mem_wdata_d  = D_wdata_i;
            // Reads always fetch the full word.
            mem_be_d     = D_write_i ? D_be_i : 4'hF;
        end else if (done_i || done_d || state_q == ST_IDLE
                     || (state_q != ST_BUSY_I && state_q != ST_BUSY_D)) begin
            // Completed with nobody waiting, sitting idle, or an unused
            // encoding: drop the strobes and rest in IDLE. A granted request
            // that drops early does not reach here, so its access keeps going.
            state_d     = ST_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking ones would create order-dependent
    // races between registers updated in the same edge.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_D;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign MEM_addr_o  = mem_addr_q;
    assign MEM_read_o  = mem_read_q;
    assign MEM_write_o = mem_write_q;
    assign MEM_wdata_o = mem_wdata_q;
    assign MEM_be_o    = mem_be_q;

    assign I_valid_o = done_i;
    assign D_valid_o = done_d;

    // Read data is a pass-through, forced to zero outside the valid pulse.
    assign I_data_o  = done_i ? MEM_data_i : 32'h0;
    assign D_rdata_o = done_d ? MEM_data_i : 32'h0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single core memory port between the instruction-fetch requester (port I) and the load/store requester (port D). It grants one outstanding access at a time using round-robin priority, latches the winning address and write data, and holds the memory request until the memory signals valid. It then routes read data back to the winner with a one-cycle valid pulse. It sits between the IF/MEM pipeline stages and the memory (later the cache).

## Interface
- BITSIZE, 32, address width of both requesters and the memory port.
- clk  in  1  core clock; all logic is on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- I_addr_i  in  BITSIZE  instruction fetch address.
- I_read_i  in  1  instruction read request; held until I_valid_o.
- I_data_o  out  32  instruction read data; meaningful only while I_valid_o.
- I_valid_o  out  1  one-cycle completion pulse for port I.
- D_addr_i  in  BITSIZE  data address.
- D_read_i  in  1  data read request; held until D_valid_o.
- D_write_i  in  1  data write request; held until D_valid_o; never high together with D_read_i.
- D_wdata_i  in  32  write data.
- D_be_i  in  4  write byte enables.
- D_rdata_o  out  32  data read data; meaningful only while D_valid_o.
- D_valid_o  out  1  one-cycle completion pulse for port D (read or write).
- MEM_addr_o  out  BITSIZE  registered address of the granted access.
- MEM_read_o  out  1  memory read strobe; held for the whole access.
- MEM_write_o  out  1  memory write strobe; held for the whole access.
- MEM_wdata_o  out  32  registered write data.
- MEM_be_o  out  4  registered byte enables; 4'hF for reads.
- MEM_data_i  in  32  memory read data.
- MEM_valid_i  in  1  memory completion; may come at the earliest in the cycle after the strobe rises.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
  - IDLE: MEM_read_o and MEM_write_o are low.
  - BUSY_x: the memory strobe is held constant until MEM_valid_i.
- Request vectors:
  - reqI = I_read_i.
  - reqD = D_read_i | D_write_i.
- Grant in IDLE:
  - Only one request: grant it.
  - Both requesting: grant the port that is not last_grant.
  - last_grant resets to D, so port I wins the first tie.
- Grant action (registered on the edge):
  - Latch MEM_addr_o, MEM_wdata_o and MEM_be_o from the winner.
  - Set MEM_read_o or MEM_write_o.
  - Enter BUSY_x and set last_grant = x.
- Completion in BUSY_x with MEM_valid_i = 1:
  - x_valid_o = 1 combinationally in the same cycle.
  - I_data_o or D_rdata_o = MEM_data_i, passed through.
  - D_valid_o also pulses for writes; D_rdata_o is don't-care on writes.
- Next state on completion:
  - The completing port's request is masked in this cycle, because it is still held.
  - If the other port requests, grant it directly with no IDLE bubble.
  - Otherwise go to IDLE.
- Requests that change or drop while not granted are ignored, with no state effect.
- A granted request dropping before completion is a protocol violation; the arbiter keeps the access running.
- MEM_valid_i in IDLE is ignored, and no valid_o pulses.
- Address and data are passed through unmodified; there is no width conversion.

## Timing
- Reset values:
  - State IDLE, last_grant = D.
  - MEM_read_o = MEM_write_o = 0.
  - MEM_addr_o = 0, MEM_wdata_o = 0, MEM_be_o = 0.
  - I_valid_o = D_valid_o = 0.
  - I_data_o = D_rdata_o = 0 whenever the corresponding valid is low.
- Reset asserted mid-access:
  - The next edge forces all the reset values.
  - The in-flight access is abandoned, and no valid_o pulses for it.
  - The memory is reset by the same reset_i.
- Latency from request in IDLE to memory strobe: 1 cycle.
- Latency from MEM_valid_i to requester valid: 0 cycles.
- Best-case request-to-valid latency: 2 cycles, with memory valid 1 cycle after the strobe.
- Back-to-back, both ports requesting continuously: the memory strobe stays high with no gap, and grants strictly alternate I, D, I, D.
- Worst-case wait for a requester while the other port is busy: one full access of the other port.

## Test plan
- Reset, then I_read_i = 1 at addr 0x100, memory valid 1 cycle after the strobe with data 0xDEADBEEF:
  - MEM_read_o rises 1 cycle after the request, with MEM_addr_o = 0x100.
  - I_valid_o pulses for 1 cycle with I_data_o = 0xDEADBEEF.
- Simultaneous I read at 0x0 and D read at 0x2000, first access after reset:
  - I is granted first, then D directly the next cycle after I's valid.
  - MEM_read_o stays high continuously.
- D_write_i with wdata 0x12345678, be 4'b0011, addr 0x40:
  - MEM_write_o = 1, MEM_wdata_o = 0x12345678, MEM_be_o = 4'b0011.
  - D_valid_o pulses on MEM_valid_i.
  - MEM_read_o stays 0 throughout.
- Both ports requesting continuously for 8 accesses with memory latency 3:
  - Grant order is I, D, I, D, I, D, I, D.
  - Exactly one valid pulse per access.
- reset_i asserted while BUSY_D with MEM_valid_i arriving in the same cycle:
  - D_valid_o = 0 in that cycle and on the next edge.
  - All outputs take reset values; the next I request is served normally.
- MEM_valid_i pulsed in IDLE with no requests: no valid_o asserted, state remains IDLE.
